// File: rtl/pe_skew_feeder_if.sv
// Stream bundle (tdata/tvalid/tready/tlast) used on both sides of the skew feeder.
//   master : drives tdata, tvalid, tlast; receives tready
//   slave  : receives tdata, tvalid, tlast; drives tready
// Handshake: a beat transfers on a rising clock edge where tvalid and tready are
// both high. A master holding tvalid keeps tdata/tlast stable until that edge, and
// tvalid never depends combinationally on tready.
interface pe_skew_feeder_if #(
  parameter int DW = 128
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pe_skew_feeder.sv
// Skewed operand feeder for a row/column of systolic MAC PEs.
// Lane i of each accepted input vector is delayed by i beats, so the output forms
// the diagonal wavefront a systolic array expects. After the input tlast the block
// flushes LANES-1 zero-fed beats to drain the trailing triangle.
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset
//   s             : input stream, LANES*WIDTH packed (lane i at [i*WIDTH +: WIDTH])
//   m             : skewed output stream, same packing, all lanes valid together
//   busy          : frame in progress (RUN or FLUSH)
//   dbg_state_o   : current FSM state (0 IDLE, 1 RUN, 2 FLUSH)
module pe_skew_feeder #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  pe_skew_feeder_if.slave       s,
  pe_skew_feeder_if.master      m,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int             CW         = $clog2(LANES) + 1;
  localparam logic [CW-1:0]  FLUSH_INIT = CW'(LANES - 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            flush_cnt_q, flush_cnt_d;
  logic [LANES*WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic                     m_tvalid_q, m_tvalid_d;
  logic                     m_tlast_q, m_tlast_d;

  logic                     flushing;
  logic                     advance;
  logic                     accept;
  logic                     shift_en;
  logic [WIDTH-1:0]         feed_w [LANES];
  logic [WIDTH-1:0]         tap_w  [LANES];

  assign flushing = (state_q == FLUSH);
  // The output register can take a new beat when empty or being drained.
  assign advance  = !m_tvalid_q || m.tready;
  assign s.tready = advance && !flushing;
  assign accept   = s.tvalid && s.tready;
  // Delay lines move on every accepted beat and on every flush beat.
  assign shift_en = accept || (flushing && advance);

  // Per-lane delay lines. During flush the feed is zero, which also leaves the
  // lines clean for the next frame's leading triangle.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign feed_w[gi] = accept ? s.tdata[gi*WIDTH +: WIDTH] : '0;
    if (gi == 0) begin : g_l0
      assign tap_w[gi] = feed_w[gi];
    end else if (gi == 1) begin : g_l1
      logic [WIDTH-1:0] line_q;
      always_ff @(posedge aclk) begin
        if (!aresetn)      line_q <= '0;
        else if (shift_en) line_q <= feed_w[gi];
      end
      assign tap_w[gi] = line_q;
    end else begin : g_ln
      // Newest stage in the low word, oldest in the high word.
      logic [gi*WIDTH-1:0] line_q;
      always_ff @(posedge aclk) begin
        if (!aresetn)      line_q <= '0;
        else if (shift_en) line_q <= {line_q[(gi-1)*WIDTH-1:0], feed_w[gi]};
      end
      assign tap_w[gi] = line_q[gi*WIDTH-1 -: WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;

    if (shift_en) begin
      for (int l = 0; l < LANES; l++) begin
        m_tdata_d[l*WIDTH +: WIDTH] = tap_w[l];
      end
      m_tvalid_d = 1'b1;
      m_tlast_d  = 1'b0;
    end else if (advance) begin
      m_tvalid_d = 1'b0;
    end

    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (s.tlast) begin
            if (LANES == 1) begin
              // No skew to drain: tlast passes straight through.
              m_tlast_d = 1'b1;
              state_d   = IDLE;
            end else begin
              state_d     = FLUSH;
              flush_cnt_d = FLUSH_INIT;
            end
          end else begin
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        if (advance) begin
          flush_cnt_d = flush_cnt_q - CW'(1);
          if (flush_cnt_q == CW'(1)) begin
            m_tlast_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
    end
  end

  assign m.tdata     = m_tdata_q;
  assign m.tvalid    = m_tvalid_q;
  assign m.tlast     = m_tlast_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Directed bench for pe_skew_feeder (WIDTH=32, LANES=4) with hand-computed
// expected output beats.
module tb_pe_skew_feeder;
  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int W     = WIDTH * LANES;
  localparam int EW    = W + 1;   // {tlast, tdata}

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  pe_skew_feeder_if #(.DW(W)) s_if ();
  pe_skew_feeder_if #(.DW(W)) m_if ();
  logic       busy;
  logic [1:0] dbg_state;

  pe_skew_feeder #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s           (s_if.slave),
    .m           (m_if.master),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  beat_t         in_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  bit            rand_rdy = 1'b0;
  bit            mon_en   = 1'b1;
  bit            held_v   = 1'b0;
  logic [EW-1:0] held;
  int            acc_cnt  = 0;
  int            flush_lo = 0;
  int            steps;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] vec4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [EW-1:0] ob(input logic last, input logic [W-1:0] d);
    return {last, d};
  endfunction

  // ---------------- driver / monitor, one clock per call ----------------
  task automatic step();
    @(negedge aclk);
    m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (in_q.size() != 0) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = in_q[0].data;
      s_if.tlast  = in_q[0].last;
    end else begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;
    end
    #1;
    if (held_v) begin
      check("hold_stable", {m_if.tlast, m_if.tdata}, held);
      check("hold_valid", EW'(m_if.tvalid), EW'(1));
    end
    if (dbg_state == 2'd2 && !s_if.tready) flush_lo++;
    if (mon_en && m_if.tvalid && m_if.tready) begin
      if (exp_q.size() == 0) check("extra_beat", EW'(m_if.tvalid), EW'(0));
      else check("out_beat", {m_if.tlast, m_if.tdata}, exp_q.pop_front());
    end
    held_v = m_if.tvalid && !m_if.tready;
    held   = {m_if.tlast, m_if.tdata};
    if (s_if.tvalid && s_if.tready) begin
      void'(in_q.pop_front());
      acc_cnt++;
    end
  endtask

  task automatic run_frames(input int budget, output int n);
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (in_q.size() != 0 || exp_q.size() != 0)
      check("timeout", EW'(in_q.size() + exp_q.size()), EW'(0));
    repeat (3) step();
  endtask

  task automatic push_frame3();
    for (int k = 0; k < 3; k++)
      in_q.push_back('{data: vec4(32'h10*k, 32'h10*k+1, 32'h10*k+2, 32'h10*k+3), last: (k == 2)});
    exp_q.push_back(ob(0, vec4(32'h00, 0, 0, 0)));
    exp_q.push_back(ob(0, vec4(32'h10, 32'h01, 0, 0)));
    exp_q.push_back(ob(0, vec4(32'h20, 32'h11, 32'h02, 0)));
    exp_q.push_back(ob(0, vec4(0, 32'h21, 32'h12, 32'h03)));
    exp_q.push_back(ob(0, vec4(0, 0, 32'h22, 32'h13)));
    exp_q.push_back(ob(1, vec4(0, 0, 0, 32'h23)));
  endtask

  task automatic push_single(input logic [31:0] a, b, c, d);
    in_q.push_back('{data: vec4(a, b, c, d), last: 1'b1});
    exp_q.push_back(ob(0, vec4(a, 0, 0, 0)));
    exp_q.push_back(ob(0, vec4(0, b, 0, 0)));
    exp_q.push_back(ob(0, vec4(0, 0, c, 0)));
    exp_q.push_back(ob(1, vec4(0, 0, 0, d)));
  endtask

  // 2-beat frame: lane i of beat k = base + 0x10*k + i
  task automatic push_frame2(input logic [31:0] b);
    in_q.push_back('{data: vec4(b+0, b+1, b+2, b+3), last: 1'b0});
    in_q.push_back('{data: vec4(b+32'h10, b+32'h11, b+32'h12, b+32'h13), last: 1'b1});
    exp_q.push_back(ob(0, vec4(b+0, 0, 0, 0)));
    exp_q.push_back(ob(0, vec4(b+32'h10, b+1, 0, 0)));
    exp_q.push_back(ob(0, vec4(0, b+32'h11, b+2, 0)));
    exp_q.push_back(ob(0, vec4(0, 0, b+32'h12, b+3)));
    exp_q.push_back(ob(1, vec4(0, 0, 0, b+32'h13)));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    aresetn     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    check("rst_tvalid", EW'(m_if.tvalid), EW'(0));
    check("rst_busy",   EW'(busy),        EW'(0));
    check("rst_tready", EW'(s_if.tready), EW'(1));
    check("rst_tdata",  EW'(m_if.tdata),  EW'(0));
    check("rst_state",  EW'(dbg_state),   EW'(0));

    // 3-beat frame, downstream always ready
    flush_lo = 0;
    push_frame3();
    run_frames(100, steps);
    check("f3_steps", EW'(steps), EW'(7));
    check("f3_flush_tready_lo", EW'(flush_lo), EW'(3));
    check("f3_idle_busy", EW'(busy), EW'(0));

    // same frame with random backpressure
    rand_rdy = 1'b1;
    push_frame3();
    run_frames(300, steps);
    rand_rdy = 1'b0;
    repeat (2) step();

    // single-beat frame
    push_single(32'hA, 32'hB, 32'hC, 32'hD);
    run_frames(100, steps);

    // two back-to-back 2-beat frames: 10 beats with no gap beyond the flush
    push_frame2(32'h000);
    push_frame2(32'h100);
    run_frames(100, steps);
    check("b2b_steps", EW'(steps), EW'(11));

    // reset mid-frame after two accepted beats
    mon_en  = 1'b0;
    acc_cnt = 0;
    push_frame3();
    steps = 0;
    while (acc_cnt < 2 && steps < 50) begin
      step();
      steps++;
    end
    check("mid_acc", EW'(acc_cnt), EW'(2));
    @(negedge aclk);
    aresetn     = 1'b0;
    s_if.tvalid = 1'b0;
    in_q.delete();
    exp_q.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("mid_rst_tvalid", EW'(m_if.tvalid), EW'(0));
    check("mid_rst_busy",   EW'(busy),        EW'(0));
    check("mid_rst_tready", EW'(s_if.tready), EW'(1));
    held_v = 1'b0;
    mon_en = 1'b1;
    push_single(32'h31, 32'h32, 32'h33, 32'h34);
    run_frames(100, steps);
    check("end_busy", EW'(busy), EW'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
